stream_normalizer: RTL and testbench

- Repacks a byte stream arriving in partially filled words, each 1..DATA_BYTES bytes, into densely packed full words.
- Every output word except the final word of a packet carries exactly DATA_BYTES bytes. The final word carries the remainder.
- Sits between a variable-width producer and a consumer that expects full beats. Both sides use a valid/ready handshake.

---
 rtl/stream_normalizer_pkg.sv | 29 ++
 rtl/byte_merge_shifter.sv | 36 +++
 rtl/stream_normalizer.sv | 119 +++++++++++
 tb/tb_stream_normalizer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/stream_normalizer_pkg.sv
// Shared helpers for the stream normalizer: byte-count decode and byte-lane shifting.
// Latency: n/a (functions only).
// Backpressure: n/a.
package stream_normalizer_pkg;

  // Upper bound on DATA_BYTES that the helpers support; the merged word of the
  // largest instance fits in twice this many bytes.
  localparam int MAX_DATA_BYTES = 64;

  typedef logic [2*MAX_DATA_BYTES*8-1:0] wide_t;

  // A count field of zero stands for a completely full word.
  function automatic int unsigned cnt_decode(input int unsigned cnt, input int unsigned nbytes);
    return (cnt == 0) ? nbytes : cnt;
  endfunction

  // Move a vector up by a whole number of byte lanes.
  function automatic wide_t byte_shl(input wide_t v, input int unsigned nbytes);
    return v << (nbytes * 8);
  endfunction

  // Ones in the lowest nbytes byte lanes, zeros above.
  function automatic wide_t byte_mask(input int unsigned nbytes);
    wide_t ones;
    ones = '1;
    return ~byte_shl(ones, nbytes);
  endfunction

endpackage

// File: rtl/byte_merge_shifter.sv
// Appends the valid input bytes after the residue bytes and splits the result into a low word and an overflow.
// Latency: purely combinational.
// Backpressure: none; has no handshake of its own.
// Ports: acc/acc_cnt residue in, in_data/n input bytes in, low_word/ovf_word/total out.
module byte_merge_shifter
  import stream_normalizer_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  localparam int CNT_W = $clog2(DATA_BYTES),
  localparam int W = 8 * DATA_BYTES
) (
  input  logic [W-9:0]     acc,
  input  logic [CNT_W-1:0] acc_cnt,
  input  logic [W-1:0]     in_data,
  input  logic [CNT_W:0]   n,
  output logic [W-1:0]     low_word,
  output logic [W-9:0]     ovf_word,
  output logic [CNT_W:0]   total
);

  logic [W-9:0]     w_acc_m;
  logic [W-1:0]     w_in_m;
  logic [2*W-9:0]   w_merged;

  // Masking both sources keeps every byte past the valid count at zero, so the
  // outputs are already zero-padded and the residue register stays clean.
  assign w_acc_m  = (W-8)'(byte_mask(32'(acc_cnt)) & wide_t'(acc));
  assign w_in_m   = W'(byte_mask(32'(n)) & wide_t'(in_data));
  // At most 2*DATA_BYTES-1 bytes are ever valid, so the top byte lane is never needed.
  assign w_merged = (2*W-8)'(wide_t'(w_acc_m) | byte_shl(wide_t'(w_in_m), 32'(acc_cnt)));

  assign low_word = w_merged[W-1:0];
  assign ovf_word = w_merged[2*W-9:W];
  assign total    = {1'b0, acc_cnt} + n;

endmodule

// File: rtl/stream_normalizer.sv
// Repacks partially filled input words into densely packed full output words, per packet.
// Latency: zero; a completing input produces its output word in the same cycle, a trailing residue one cycle later.
// Backpressure: in_ready follows out_ready whenever the input generates output; input stalls during a residue flush.
// Ports: clk, rst_n; in_data/in_cnt/in_last/in_valid/in_ready; out_data/out_cnt/out_last/out_valid/out_ready.
module stream_normalizer
  import stream_normalizer_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  localparam int CNT_W = $clog2(DATA_BYTES),
  localparam int W = 8 * DATA_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(DATA_BYTES);

  logic [W-9:0]     r_acc;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_flush;

  logic [CNT_W:0]   w_n;
  logic [W-1:0]     w_low;
  logic [W-9:0]     w_ovf;
  logic [CNT_W:0]   w_total;
  logic [CNT_W:0]   w_rem;
  logic             w_in_hs;
  logic             w_flush_hs;

  assign w_n   = (CNT_W+1)'(cnt_decode(32'(in_cnt), DATA_BYTES));
  assign w_rem = w_total - FULL;

  byte_merge_shifter #(
    .DATA_BYTES (DATA_BYTES)
  ) u_merge (
    .acc      (r_acc),
    .acc_cnt  (r_acc_cnt),
    .in_data  (in_data),
    .n        (w_n),
    .low_word (w_low),
    .ovf_word (w_ovf),
    .total    (w_total)
  );

  // Output decode. Everything is forced idle while rst_n is low so neither side
  // can see a handshake during reset.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_cnt   = '0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    if (rst_n) begin
      if (r_flush) begin
        out_valid = 1'b1;
        out_data  = {8'h00, r_acc};
        out_cnt   = r_acc_cnt;
        out_last  = 1'b1;
      end else if (!in_valid) begin
        in_ready  = 1'b1;
      end else if (w_total < FULL) begin
        if (in_last) begin
          out_valid = 1'b1;
          out_data  = w_low;
          out_cnt   = w_total[CNT_W-1:0];
          out_last  = 1'b1;
          in_ready  = out_ready;
        end else begin
          in_ready  = 1'b1;
        end
      end else begin
        // Exactly full or overflowing: the low word is a full beat. Only an
        // exact fit may end the packet here; an overflow defers last to the flush.
        out_valid = 1'b1;
        out_data  = w_low;
        out_last  = (w_total == FULL) ? in_last : 1'b0;
        in_ready  = out_ready;
      end
    end
  end

  assign w_in_hs    = in_valid & in_ready;
  assign w_flush_hs = r_flush & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_flush   <= 1'b0;
    end else if (w_flush_hs) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
      r_flush   <= 1'b0;
    end else if (w_in_hs) begin
      if (w_total < FULL && !in_last) begin
        r_acc     <= w_low[W-9:0];
        r_acc_cnt <= w_total[CNT_W-1:0];
      end else if (w_total > FULL) begin
        r_acc     <= w_ovf;
        r_acc_cnt <= w_rem[CNT_W-1:0];
        r_flush   <= in_last;
      end else begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_normalizer.sv
module tb_stream_normalizer;

  localparam logic [63:0] PAT = 64'h0123456789abcdef;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [2:0]  in_cnt;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int total_cnt = 0;
  int bad_cnt   = 0;

  stream_normalizer #(
    .DATA_BYTES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Called at a falling edge: drive one cycle of input, check the combinational
  // outputs before the rising edge, then advance to the next falling edge.
  task automatic beat(input string tag, input logic vld, input logic [2:0] c, input logic l,
                      input logic exp_ovld, input logic [63:0] exp_dat, input logic [2:0] exp_cnt,
                      input logic exp_last, input logic exp_rdy);
    in_data  = PAT;
    in_cnt   = c;
    in_last  = l;
    in_valid = vld;
    #1;
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(exp_ovld));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (exp_ovld) begin
      check_eq({tag, ".out_data"}, out_data, exp_dat);
      check_eq({tag, ".out_cnt"}, 64'(out_cnt), 64'(exp_cnt));
      check_eq({tag, ".out_last"}, 64'(out_last), 64'(exp_last));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = PAT;
    in_cnt    = 3'd4;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    beat("idle", 1'b0, 3'd0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);

    // Two half words complete one full beat.
    beat("split.a", 1'b1, 3'd4, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("split.b", 1'b1, 3'd4, 1'b1, 1'b1, 64'h89abcdef89abcdef, 3'd0, 1'b1, 1'b1);

    // Overflow with last: full beat, then the residue flush with input stalled.
    beat("ovf.a", 1'b1, 3'd7, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("ovf.b", 1'b1, 3'd7, 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0, 1'b1);
    beat("ovf.flush", 1'b1, 3'd4, 1'b1, 1'b1, 64'h000023456789abcd, 3'd6, 1'b1, 1'b0);

    // Single partial and single full packets.
    beat("single.part", 1'b1, 3'd4, 1'b1, 1'b1, 64'h0000000089abcdef, 3'd4, 1'b1, 1'b1);
    beat("single.full", 1'b1, 3'd0, 1'b1, 1'b1, 64'h0123456789abcdef, 3'd0, 1'b1, 1'b1);

    // Full word landing on a 7-byte residue.
    beat("fop.a", 1'b1, 3'd7, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("fop.b", 1'b1, 3'd0, 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0, 1'b1);
    beat("fop.flush", 1'b0, 3'd0, 1'b0, 1'b1, 64'h000123456789abcd, 3'd7, 1'b1, 1'b0);

    // Eight single bytes build one full word.
    for (int i = 0; i < 7; i++)
      beat("ones.acc", 1'b1, 3'd1, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("ones.last", 1'b1, 3'd1, 1'b1, 1'b1, 64'hefefefefefefefef, 3'd0, 1'b1, 1'b1);

    beat("three.a", 1'b1, 3'd3, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("three.b", 1'b1, 3'd3, 1'b1, 1'b1, 64'h0000abcdefabcdef, 3'd6, 1'b1, 1'b1);

    // Backpressure on a completing input: output holds steady, input stalls.
    beat("bp.a", 1'b1, 3'd4, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    out_ready = 1'b0;
    beat("bp.hold0", 1'b1, 3'd4, 1'b1, 1'b1, 64'h89abcdef89abcdef, 3'd0, 1'b1, 1'b0);
    beat("bp.hold1", 1'b1, 3'd4, 1'b1, 1'b1, 64'h89abcdef89abcdef, 3'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    beat("bp.go", 1'b1, 3'd4, 1'b1, 1'b1, 64'h89abcdef89abcdef, 3'd0, 1'b1, 1'b1);

    // Backpressure on a flush: the residue word waits for the consumer.
    beat("bpf.a", 1'b1, 3'd7, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    beat("bpf.b", 1'b1, 3'd7, 1'b1, 1'b1, 64'hef23456789abcdef, 3'd0, 1'b0, 1'b1);
    out_ready = 1'b0;
    beat("bpf.hold", 1'b0, 3'd0, 1'b0, 1'b1, 64'h000023456789abcd, 3'd6, 1'b1, 1'b0);
    out_ready = 1'b1;
    beat("bpf.go", 1'b0, 3'd0, 1'b0, 1'b1, 64'h000023456789abcd, 3'd6, 1'b1, 1'b0);
    beat("bpf.idle", 1'b0, 3'd0, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);

    // Reset in the middle of a packet drops the residue.
    beat("mid.a", 1'b1, 3'd4, 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_cnt   = 3'd4;
    in_last  = 1'b1;
    #1;
    check_eq("mid.rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("mid.rst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat("mid.after", 1'b1, 3'd4, 1'b1, 1'b1, 64'h0000000089abcdef, 3'd4, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
